fip_div_seq: RTL

- Parametrised, multi-cycle signed fixed-point divider computing z = x / y in Q(WIDTH-FRA_BITS).FRA_BITS.
- Successor to the combinational 32-bit fixed-point divide. Adds:
  - generic width and fraction bits;
  - a start/busy/valid handshake;
  - a restoring shift-subtract core producing one quotient bit per cycle;
  - divide-by-zero and overflow flags;
  - a selectable saturate or wrap mode.
- Used by vector normalisation and ray-intersection stages where a full-width combinational divider does not close timing.

---
 rtl/fip_pkg.sv | 17 +
 rtl/fip_div_seq_if.sv | 16 +
 rtl/fip_sat_narrow.sv | 28 ++
 rtl/fip_div_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/fip_pkg.sv
// fip_pkg: shared types, constants and range helpers for the fixed-point operators
package fip_pkg;

   localparam logic FIP_TRUE  = 1'b1;
   localparam logic FIP_FALSE = 1'b0;

   typedef enum logic [1:0] {IDLE, RUN, FIX} fip_div_state_t;

   function automatic logic signed [63:0] fip_max(int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] fip_min(int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/fip_div_seq_if.sv
// fip_div_seq_if: request/result bundle of the sequential fixed-point divider
interface fip_div_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             i_en;
   logic [WIDTH-1:0] i_x;
   logic [WIDTH-1:0] i_y;
   logic [WIDTH-1:0] o_z;
   logic             o_busy;
   logic             o_valid;
   logic             o_dz;
   logic             o_ovf;

   modport master (output i_en, i_x, i_y, input o_z, o_busy, o_valid, o_dz, o_ovf);
   modport slave  (input i_en, i_x, i_y, output o_z, o_busy, o_valid, o_dz, o_ovf);
endinterface

// File: rtl/fip_sat_narrow.sv
// fip_sat_narrow: signed narrowing from IN_W to OUT_W bits with clamp or wrap and an overflow flag
module fip_sat_narrow
   import fip_pkg::*;
#(
   parameter int IN_W  = 49,
   parameter int OUT_W = 32,
   parameter bit SAT   = 1'b0
) (
   input  logic signed [IN_W-1:0] a_i,
   output logic [OUT_W-1:0]       z_o,
   output logic                   ovf_o
);
   localparam logic signed [63:0] MAX_V = fip_max(OUT_W);
   localparam logic signed [63:0] MIN_V = fip_min(OUT_W);

   logic signed [63:0] a_w;
   logic               hi;
   logic               lo;

   // Range-check the sign-extended value, then clamp (SAT) or keep the low bits
   always_comb begin
      a_w   = 64'(a_i);
      hi    = a_w > MAX_V;
      lo    = a_w < MIN_V;
      ovf_o = hi | lo;
      z_o   = (SAT && hi) ? MAX_V[OUT_W-1:0] : (SAT && lo) ? MIN_V[OUT_W-1:0] : a_i[OUT_W-1:0];
   end
endmodule

// File: rtl/fip_div_seq.sv
// fip_div_seq: multi-cycle signed fixed-point divider, one restoring quotient bit per cycle
module fip_div_seq
   import fip_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRA_BITS = 16,
   parameter bit SAT      = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   fip_div_seq_if.slave  bus
);
   localparam int N  = WIDTH + FRA_BITS;
   localparam int CW = $clog2(N + 1);
   localparam logic signed [63:0] MAX_L = fip_max(WIDTH);
   localparam logic signed [63:0] MIN_L = fip_min(WIDTH);
   localparam logic [WIDTH-1:0]   MAX_Z = MAX_L[WIDTH-1:0];
   localparam logic [WIDTH-1:0]   MIN_Z = MIN_L[WIDTH-1:0];

   fip_div_state_t   state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   ay_q;
   logic [N-1:0]     dvd_q;
   logic             sx_q;
   logic             sq_q;
   logic             dz_q;
   logic [WIDTH-1:0] z_q;
   logic             busy_q;
   logic             valid_q;
   logic             dzo_q;
   logic             ovf_q;

   logic [WIDTH-1:0]   ax;
   logic [WIDTH-1:0]   ay;
   logic [WIDTH+1:0]   rem_sh;
   logic               ge;
   logic [WIDTH:0]     rem_d;
   logic signed [N:0]  q_s;
   logic [WIDTH-1:0]   nz;
   logic               n_ovf;

   // Operand magnitudes (|MIN| wraps to 2^(WIDTH-1), correct as unsigned) and one shift-subtract step
   always_comb begin
      ax     = bus.i_x[WIDTH-1] ? -bus.i_x : bus.i_x;
      ay     = bus.i_y[WIDTH-1] ? -bus.i_y : bus.i_y;
      rem_sh = {rem_q, dvd_q[N-1]};
      ge     = rem_sh >= (WIDTH+2)'(ay_q);
      rem_d  = (WIDTH+1)'(ge ? rem_sh - (WIDTH+2)'(ay_q) : rem_sh);
      q_s    = sq_q ? -$signed({1'b0, dvd_q}) : $signed({1'b0, dvd_q});
   end

   fip_sat_narrow #(.IN_W(N + 1), .OUT_W(WIDTH), .SAT(SAT)) u_narrow (
      .a_i   (q_s),
      .z_o   (nz),
      .ovf_o (n_ovf)
   );

   // Sequencer: accept in IDLE, N quotient steps in RUN (dividend register fills with the quotient), result in FIX
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         ay_q    <= '0;
         dvd_q   <= '0;
         sx_q    <= FIP_FALSE;
         sq_q    <= FIP_FALSE;
         dz_q    <= FIP_FALSE;
         z_q     <= '0;
         busy_q  <= FIP_FALSE;
         valid_q <= FIP_FALSE;
         dzo_q   <= FIP_FALSE;
         ovf_q   <= FIP_FALSE;
      end else begin
         valid_q <= FIP_FALSE;
         case (state_q)
            IDLE: if (bus.i_en) begin
               state_q <= RUN;
               busy_q  <= FIP_TRUE;
               cnt_q   <= '0;
               rem_q   <= '0;
               ay_q    <= {1'b0, ay};
               dvd_q   <= {ax, {FRA_BITS{1'b0}}};
               sx_q    <= bus.i_x[WIDTH-1];
               sq_q    <= bus.i_x[WIDTH-1] ^ bus.i_y[WIDTH-1];
               dz_q    <= bus.i_y == '0;
            end
            RUN: begin
               rem_q   <= rem_d;
               dvd_q   <= {dvd_q[N-2:0], ge};
               cnt_q   <= cnt_q + 1'b1;
               state_q <= (cnt_q == CW'(N - 1)) ? FIX : RUN;
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= FIP_FALSE;
               valid_q <= FIP_TRUE;
               z_q     <= dz_q ? (sx_q ? MIN_Z : MAX_Z) : nz;
               dzo_q   <= dz_q;
               ovf_q   <= !dz_q && n_ovf;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_z     = z_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_valid = valid_q;
   assign bus.o_dz    = dzo_q;
   assign bus.o_ovf   = ovf_q;
endmodule
